// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//
// Sequencing FSM for a multicycle RISC-V datapath that shares one ALU and one
// unified instruction/data memory across cycles. It decodes the latched
// instruction fields, walks the datapath through fetch / decode / execute /
// memory / writeback, drives every mux select and write enable, waits on the
// memory-ready handshake and counts retired instructions. Unsupported
// encodings park the controller in HALT until reset.
//
// Ports:
//   i_clk        rising-edge clock
//   i_arst_n     asynchronous active-low reset
//   i_operand    instruction[6:0] (opcode) from the instruction register
//   i_funct3     instruction[14:12]
//   i_funct7b5   instruction[30]
//   i_zero       ALU zero flag
//   i_memReady   memory completes the current access this cycle
//   o_pcUpdate   PC write enable
//   o_adrSrc     memory address select (0 = PC, 1 = result)
//   o_irWrite    instruction register / oldPC write enable
//   o_memWrite   memory write strobe
//   o_regWrite   register file write enable
//   o_resultSrc  result select (00 aluOut, 01 read data, 10 ALU direct)
//   o_aluSrcA    ALU A select (00 PC, 01 oldPC, 10 rs1)
//   o_aluSrcB    ALU B select (00 rs2, 01 immediate, 10 constant 4)
//   o_aluControl ALU op (ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLT 5)
//   o_state      current state encoding
//   o_illegal    controller is halted
//   o_instret    retired-instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    input  logic [6:0]           i_operand,
    input  logic [2:0]           i_funct3,
    input  logic                 i_funct7b5,
    input  logic                 i_zero,
    input  logic                 i_memReady,
    output logic                 o_pcUpdate,
    output logic                 o_adrSrc,
    output logic                 o_irWrite,
    output logic                 o_memWrite,
    output logic                 o_regWrite,
    output logic [1:0]           o_resultSrc,
    output logic [1:0]           o_aluSrcA,
    output logic [1:0]           o_aluSrcB,
    output logic [3:0]           o_aluControl,
    output logic [3:0]           o_state,
    output logic                 o_illegal,
    output logic [INSTRET_W-1:0] o_instret
);

    localparam logic [3:0] FETCH    = 4'd0;
    localparam logic [3:0] DECODE   = 4'd1;
    localparam logic [3:0] MEMADR   = 4'd2;
    localparam logic [3:0] MEMREAD  = 4'd3;
    localparam logic [3:0] MEMWB    = 4'd4;
    localparam logic [3:0] MEMWRITE = 4'd5;
    localparam logic [3:0] EXECUTER = 4'd6;
    localparam logic [3:0] EXECUTEI = 4'd7;
    localparam logic [3:0] ALUWB    = 4'd8;
    localparam logic [3:0] JAL      = 4'd9;
    localparam logic [3:0] BEQ      = 4'd10;
    localparam logic [3:0] HALT     = 4'd15;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;

    localparam logic [INSTRET_W-1:0] INSTRET_ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

    logic [3:0]           stateReg;
    logic [3:0]           stateNext;
    logic [INSTRET_W-1:0] instretReg;
    logic                 retire;

    // Enables before reset gating; the reset state is FETCH, whose
    // irWrite/pcUpdate follow i_memReady, so they must be masked explicitly.
    logic pcUpdateRaw;
    logic irWriteRaw;
    logic memWriteRaw;
    logic regWriteRaw;

    // funct3 values with no supported ALU operation (shifts, sltu).
    logic badAluFunct3;
    // funct7b5 only selects SUB; with any other funct3 it names an
    // unsupported R-type (e.g. sra).
    logic badSub;

    assign badAluFunct3 = (i_funct3 == 3'b001) || (i_funct3 == 3'b011) ||
                          (i_funct3 == 3'b101);
    assign badSub       = i_funct7b5 && (i_funct3 != 3'b000);

    function automatic logic [3:0] aluFromFunct3(input logic [2:0] funct3,
                                                 input logic       useSub);
        logic [3:0] op;
        op = ALU_ADD;
        case (funct3)
            3'b000:  op = useSub ? ALU_SUB : ALU_ADD;
            3'b010:  op = ALU_SLT;
            3'b100:  op = ALU_XOR;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // State and retire counter.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            stateReg   <= FETCH;
            instretReg <= '0;
        end else begin
            stateReg <= stateNext;
            if (retire) begin
                instretReg <= instretReg + INSTRET_ONE;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            FETCH:    if (i_memReady) stateNext = DECODE;
            DECODE: begin
                case (i_operand)
                    OP_LOAD, OP_STORE: stateNext = MEMADR;
                    OP_R:     stateNext = (badAluFunct3 || badSub) ? HALT : EXECUTER;
                    OP_I:     stateNext = badAluFunct3 ? HALT : EXECUTEI;
                    OP_JAL:   stateNext = JAL;
                    OP_BEQ:   stateNext = BEQ;
                    default:  stateNext = HALT;
                endcase
            end
            // Opcode bit 5 separates stores (0100011) from loads (0000011).
            MEMADR:   stateNext = i_operand[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (i_memReady) stateNext = MEMWB;
            MEMWB:    stateNext = FETCH;
            MEMWRITE: if (i_memReady) stateNext = FETCH;
            EXECUTER: stateNext = ALUWB;
            EXECUTEI: stateNext = ALUWB;
            ALUWB:    stateNext = FETCH;
            JAL:      stateNext = ALUWB;
            BEQ:      stateNext = FETCH;
            HALT:     stateNext = HALT;
            default:  stateNext = HALT;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    assign retire = (stateReg == MEMWB) || (stateReg == ALUWB) ||
                    (stateReg == BEQ)   ||
                    ((stateReg == MEMWRITE) && i_memReady);

    // Output decode.
    always_comb begin
        pcUpdateRaw  = 1'b0;
        irWriteRaw   = 1'b0;
        memWriteRaw  = 1'b0;
        regWriteRaw  = 1'b0;
        o_adrSrc     = 1'b0;
        o_resultSrc  = 2'b00;
        o_aluSrcA    = 2'b00;
        o_aluSrcB    = 2'b00;
        o_aluControl = ALU_ADD;
        o_illegal    = 1'b0;
        case (stateReg)
            FETCH: begin
                o_aluSrcB   = 2'b10;
                o_resultSrc = 2'b10;
                irWriteRaw  = i_memReady;
                pcUpdateRaw = i_memReady;
            end
            DECODE: begin
                o_aluSrcA = 2'b01;
                o_aluSrcB = 2'b01;
            end
            MEMADR: begin
                o_aluSrcA = 2'b10;
                o_aluSrcB = 2'b01;
            end
            MEMREAD: begin
                o_adrSrc = 1'b1;
            end
            MEMWB: begin
                o_resultSrc = 2'b01;
                regWriteRaw = 1'b1;
            end
            MEMWRITE: begin
                o_adrSrc    = 1'b1;
                memWriteRaw = 1'b1;
            end
            EXECUTER: begin
                o_aluSrcA    = 2'b10;
                o_aluControl = aluFromFunct3(i_funct3, i_funct7b5);
            end
            EXECUTEI: begin
                o_aluSrcA    = 2'b10;
                o_aluSrcB    = 2'b01;
                o_aluControl = aluFromFunct3(i_funct3, 1'b0);
            end
            ALUWB: begin
                regWriteRaw = 1'b1;
            end
            JAL: begin
                // ALU forms the link value oldPC+4 while the jump target,
                // computed in DECODE, is taken from aluOut.
                o_aluSrcA   = 2'b01;
                o_aluSrcB   = 2'b10;
                pcUpdateRaw = 1'b1;
            end
            BEQ: begin
                o_aluSrcA    = 2'b10;
                o_aluControl = ALU_SUB;
                pcUpdateRaw  = i_zero;
            end
            HALT: begin
                o_illegal = 1'b1;
            end
            default: begin
                o_illegal = 1'b0;
            end
        endcase
    end

    assign o_pcUpdate = pcUpdateRaw & i_arst_n;
    assign o_irWrite  = irWriteRaw  & i_arst_n;
    assign o_memWrite = memWriteRaw & i_arst_n;
    assign o_regWrite = regWriteRaw & i_arst_n;
    assign o_state    = stateReg;
    assign o_instret  = instretReg;

endmodule
